// File: rtl/alarm_scheduler.sv
// alarm_scheduler
//   Multi-slot alarm controller sitting between the BCD watch counter and the
//   shared sound generator. Holds NUM_SLOTS programmable alarm times, compares
//   them against time_now on every sec_tick, arbitrates simultaneous matches
//   (lowest index first) and sequences ring / snooze / stop / timeout.
//
// Handshake / strobe semantics:
//   sec_tick, wr_en, stop_btn and snooze_btn are single-cycle strobes sampled
//   on the rising clk edge; there is no back-pressure. Priority on a single
//   edge is: config-write cancel > stop_btn > snooze_btn > sec_tick expiry.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   sec_tick           one-clk pulse per second
//   time_now[15:0]     current BCD time {hour10, hour1, min10, min1}
//   wr_en/wr_slot/wr_time/wr_enable   slot configuration write
//   stop_btn, snooze_btn              user requests (single-cycle pulses)
//   aud_en             registered sound enable
//   state_o[1:0]       FSM state: 00 IDLE, 01 RING, 10 SNOOZE
//   active_slot        slot currently ringing or snoozed
//   snooze_cnt[1:0]    snoozes used in the current event
//   pending            matched slots waiting for service
module alarm_scheduler #(
    parameter int NUM_SLOTS        = 4,
    parameter int SLOT_W           = 2,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZE       = 3,
    parameter int CNT_W            = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sec_tick,
    input  logic [15:0]          time_now,
    input  logic                 wr_en,
    input  logic [SLOT_W-1:0]    wr_slot,
    input  logic [15:0]          wr_time,
    input  logic                 wr_enable,
    input  logic                 stop_btn,
    input  logic                 snooze_btn,
    output logic                 aud_en,
    output logic [1:0]           state_o,
    output logic [SLOT_W-1:0]    active_slot,
    output logic [1:0]           snooze_cnt,
    output logic [NUM_SLOTS-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RING   = 2'b01,
        SNOOZE = 2'b10
    } state_t;

    logic [15:0]          slot_time [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_en;
    logic [NUM_SLOTS-1:0] fired_mask;
    logic [NUM_SLOTS-1:0] match;
    logic [NUM_SLOTS-1:0] pending_r;

    state_t               state, state_d;
    logic [SLOT_W-1:0]    active_r, active_d;
    logic [1:0]           snz_r, snz_d;
    logic [CNT_W-1:0]     cnt_r, cnt_d;
    logic                 aud_r, aud_d;

    logic [SLOT_W-1:0]    pick_idx;
    logic                 pick_valid;
    logic                 pend_clr;
    logic                 cancel;

    // A slot fires at most once per matching minute: fired_mask blocks
    // re-matching until a tick where the slot time differs from time_now.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = sec_tick & slot_en[i] & (slot_time[i] == time_now) & ~fired_mask[i];
        end
    end

    // Lowest-index pending slot wins; scan downward so the last hit is lowest.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending_r[i]) begin
                pick_valid = 1'b1;
                pick_idx   = SLOT_W'(i);
            end
        end
    end

    // Slot storage, fired mask and pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_time[i] <= '0;
            end
            slot_en    <= '0;
            fired_mask <= '0;
            pending_r  <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (sec_tick) begin
                    if (slot_time[i] != time_now) begin
                        fired_mask[i] <= 1'b0;
                    end else if (match[i]) begin
                        fired_mask[i] <= 1'b1;
                    end
                end
                // A write re-arms the slot even if it fired this minute.
                if (wr_en && (wr_slot == SLOT_W'(i))) begin
                    slot_time[i]  <= wr_time;
                    slot_en[i]    <= wr_enable;
                    fired_mask[i] <= 1'b0;
                end
                if (match[i]) begin
                    pending_r[i] <= 1'b1;
                end else if (pend_clr && (pick_idx == SLOT_W'(i))) begin
                    pending_r[i] <= 1'b0;
                end
            end
        end
    end

    // FSM state and event registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            active_r <= '0;
            snz_r    <= '0;
            cnt_r    <= '0;
            aud_r    <= 1'b0;
        end else begin
            state    <= state_d;
            active_r <= active_d;
            snz_r    <= snz_d;
            cnt_r    <= cnt_d;
            aud_r    <= aud_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state;
        active_d = active_r;
        snz_d    = snz_r;
        cnt_d    = cnt_r;
        aud_d    = aud_r;
        pend_clr = 1'b0;
        cancel   = wr_en && (state != IDLE) && (wr_slot == active_r);

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = RING;
                    active_d = pick_idx;
                    pend_clr = 1'b1;
                    aud_d    = 1'b1;
                    cnt_d    = CNT_W'(RING_TIMEOUT_SEC);
                end
            end

            RING: begin
                // Snooze past the allowance behaves exactly like stop.
                if (cancel || stop_btn ||
                    (snooze_btn && (snz_r == 2'(MAX_SNOOZE)))) begin
                    state_d = IDLE;
                    aud_d   = 1'b0;
                    snz_d   = '0;
                end else if (snooze_btn) begin
                    state_d = SNOOZE;
                    aud_d   = 1'b0;
                    cnt_d   = CNT_W'(SNOOZE_SEC);
                    snz_d   = snz_r + 2'd1;
                end else if (sec_tick) begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_d = IDLE;
                        aud_d   = 1'b0;
                        snz_d   = '0;
                    end else begin
                        cnt_d = cnt_r - CNT_W'(1);
                    end
                end
            end

            SNOOZE: begin
                if (cancel || stop_btn) begin
                    state_d = IDLE;
                    aud_d   = 1'b0;
                    snz_d   = '0;
                end else if (sec_tick) begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_d = RING;
                        aud_d   = 1'b1;
                        cnt_d   = CNT_W'(RING_TIMEOUT_SEC);
                    end else begin
                        cnt_d = cnt_r - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                aud_d   = 1'b0;
                snz_d   = '0;
            end
        endcase
    end

    assign aud_en      = aud_r;
    assign state_o     = state;
    assign active_slot = active_r;
    assign snooze_cnt  = snz_r;
    assign pending     = pending_r;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed testbench for alarm_scheduler. Inputs change on the falling clk
// edge and outputs are sampled there too, away from the active rising edge.
module tb_alarm_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        sec_tick;
    logic [15:0] time_now;
    logic        wr_en;
    logic [1:0]  wr_slot;
    logic [15:0] wr_time;
    logic        wr_enable;
    logic        stop_btn;
    logic        snooze_btn;
    logic        aud_en;
    logic [1:0]  state_o;
    logic [1:0]  active_slot;
    logic [1:0]  snooze_cnt;
    logic [3:0]  pending;

    int vectors    = 0;
    int miscompares = 0;

    // clock / reset
    always #5 clk = ~clk;

    alarm_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .sec_tick   (sec_tick),
        .time_now   (time_now),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .wr_time    (wr_time),
        .wr_enable  (wr_enable),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .aud_en     (aud_en),
        .state_o    (state_o),
        .active_slot(active_slot),
        .snooze_cnt (snooze_cnt),
        .pending    (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks: called at a falling edge, assert for exactly one rising edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] s, input logic [15:0] t, input logic e);
        wr_en = 1'b1; wr_slot = s; wr_time = t; wr_enable = e;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic press(input logic stp, input logic snz);
        stop_btn = stp; snooze_btn = snz;
        @(negedge clk);
        stop_btn = 1'b0; snooze_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sec_tick = 1'b0; time_now = 16'h0000;
        wr_en = 1'b0; wr_slot = 2'd0; wr_time = 16'h0000; wr_enable = 1'b0;
        stop_btn = 1'b0; snooze_btn = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        // reset state
        chk("rst_aud", aud_en, 0);
        chk("rst_state", state_o, 0);
        chk("rst_slot", active_slot, 0);
        chk("rst_snz", snooze_cnt, 0);
        chk("rst_pend", pending, 0);

        // single alarm, latency and timeout
        wr(2'd0, 16'h0730, 1'b1);
        time_now = 16'h0729; tick();
        time_now = 16'h0730; tick();
        chk("lat1_aud", aud_en, 0);
        chk("lat1_pend", pending, 4'b0001);
        step(1);
        chk("lat2_aud", aud_en, 1);
        chk("lat2_state", state_o, 2'b01);
        chk("lat2_slot", active_slot, 0);
        chk("lat2_pend", pending, 0);
        ticks(59);
        chk("to59_aud", aud_en, 1);
        chk("to59_state", state_o, 2'b01);
        tick();
        chk("to60_aud", aud_en, 0);
        chk("to60_state", state_o, 2'b00);
        ticks(3);
        step(2);
        chk("norefire_aud", aud_en, 0);
        chk("norefire_pend", pending, 0);

        // snooze chain on slot0
        time_now = 16'h0731; tick();
        time_now = 16'h0730; tick();
        step(1);
        chk("sn_ring", state_o, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            press(1'b0, 1'b1);
            chk("sn_state", state_o, 2'b10);
            chk("sn_aud", aud_en, 0);
            chk("sn_cnt", snooze_cnt, k);
            ticks(299);
            chk("sn299_state", state_o, 2'b10);
            tick();
            chk("sn300_state", state_o, 2'b01);
            chk("sn300_aud", aud_en, 1);
            chk("sn300_cnt", snooze_cnt, k);
            chk("sn300_slot", active_slot, 0);
        end
        press(1'b0, 1'b1);
        chk("sn4_state", state_o, 2'b00);
        chk("sn4_cnt", snooze_cnt, 0);
        chk("sn4_aud", aud_en, 0);

        // arbitration
        wr(2'd1, 16'h0600, 1'b1);
        wr(2'd3, 16'h0600, 1'b1);
        time_now = 16'h0600; tick();
        chk("arb_pend0", pending, 4'b1010);
        step(1);
        chk("arb_slot1", active_slot, 1);
        chk("arb_state1", state_o, 2'b01);
        chk("arb_pend1", pending, 4'b1000);
        press(1'b1, 1'b0);
        chk("arb_stop_state", state_o, 2'b00);
        chk("arb_stop_aud", aud_en, 0);
        step(1);
        chk("arb_slot3", active_slot, 3);
        chk("arb_state3", state_o, 2'b01);
        chk("arb_aud3", aud_en, 1);
        chk("arb_pend3", pending, 0);

        // simultaneous stop + snooze: stop wins
        press(1'b1, 1'b1);
        chk("both_state", state_o, 2'b00);
        chk("both_cnt", snooze_cnt, 0);
        chk("both_aud", aud_en, 0);

        // config cancel during SNOOZE of slot2
        wr(2'd2, 16'h0615, 1'b1);
        time_now = 16'h0615; tick();
        step(1);
        chk("cc_slot", active_slot, 2);
        press(1'b0, 1'b1);
        chk("cc_snooze", state_o, 2'b10);
        wr(2'd2, 16'h0615, 1'b0);
        chk("cc_state", state_o, 2'b00);
        chk("cc_cnt", snooze_cnt, 0);
        chk("cc_aud", aud_en, 0);
        ticks(300);
        step(1);
        chk("cc_exp_state", state_o, 2'b00);
        chk("cc_exp_aud", aud_en, 0);

        // async reset mid-RING with another slot pending
        wr(2'd0, 16'h0800, 1'b1);
        wr(2'd1, 16'h0800, 1'b1);
        time_now = 16'h0800; tick();
        step(1);
        chk("mr_state", state_o, 2'b01);
        chk("mr_pend", pending, 4'b0010);
        rst = 1'b1;
        #1;
        chk("ar_aud", aud_en, 0);
        chk("ar_state", state_o, 0);
        chk("ar_pend", pending, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        time_now = 16'h0801; tick();
        time_now = 16'h0800; tick();
        step(2);
        chk("post_rst_aud", aud_en, 0);
        chk("post_rst_pend", pending, 0);
        chk("post_rst_state", state_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
